// File: rtl/xy2_100_tx.sv
// XY2-100 galvo transmitter: captures (x, y) on a rising xy2_send and shifts
// 20-bit parity-protected frames onto parallel X/Y lines with clock and sync.
module xy2_100_tx #(
  parameter int unsigned CLK_DIV = 25,
  parameter bit          REPEAT  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x_coord,
  input  logic [15:0] y_coord,
  input  logic        xy2_send,
  output logic        xy2_clk,
  output logic        xy2_sync,
  output logic        xy2_x,
  output logic        xy2_y,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned DW = 16;
  localparam int unsigned FW = 20;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [4:0]    BIT_TOP  = 5'(FW - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic          phase, phase_n;   // 0 = line clock high half, 1 = low half
  logic [4:0]    bit_cnt, bit_n;
  logic [FW-1:0] sh_x, sh_y, shx_n, shy_n;
  logic [DW-1:0] pend_x, pend_y, hold_x, hold_y;
  logic          pending, send_q;
  logic          capture_c, load_pend_c, load_hold_c;

  function automatic logic [FW-1:0] mk_frame(input logic [DW-1:0] d);
    return {3'b001, d, ~(^d)};
  endfunction

  assign capture_c = xy2_send && !send_q;

  // Next-state: divider/bit counter sequencing and frame (re)loading
  always_comb begin
    state_n     = state;
    div_n       = div_cnt;
    phase_n     = phase;
    bit_n       = bit_cnt;
    shx_n       = sh_x;
    shy_n       = sh_y;
    load_pend_c = 1'b0;
    load_hold_c = 1'b0;
    case (state)
      IDLE: begin
        if (pending) load_pend_c = 1'b1;
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (!phase) begin
            phase_n = 1'b1;
          end else if (bit_cnt == 5'd0) begin
            if (pending)     load_pend_c = 1'b1;
            else if (REPEAT) load_hold_c = 1'b1;
            else begin
              state_n = IDLE;
              phase_n = 1'b0;
            end
          end else begin
            phase_n = 1'b0;
            bit_n   = bit_cnt - 5'd1;
            shx_n   = {sh_x[FW-2:0], 1'b0};
            shy_n   = {sh_y[FW-2:0], 1'b0};
          end
        end else begin
          div_n = div_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (load_pend_c || load_hold_c) begin
      state_n = SHIFT;
      div_n   = '0;
      phase_n = 1'b0;
      bit_n   = BIT_TOP;
      shx_n   = mk_frame(load_pend_c ? pend_x : hold_x);
      shy_n   = mk_frame(load_pend_c ? pend_y : hold_y);
    end
  end

  // State, capture path and registered line outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      phase      <= 1'b0;
      bit_cnt    <= '0;
      sh_x       <= '0;
      sh_y       <= '0;
      pend_x     <= '0;
      pend_y     <= '0;
      hold_x     <= '0;
      hold_y     <= '0;
      pending    <= 1'b0;
      send_q     <= 1'b0;
      xy2_clk    <= 1'b0;
      xy2_sync   <= 1'b0;
      xy2_x      <= 1'b0;
      xy2_y      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      phase   <= phase_n;
      bit_cnt <= bit_n;
      sh_x    <= shx_n;
      sh_y    <= shy_n;
      send_q  <= xy2_send;
      if (load_pend_c) begin
        hold_x <= pend_x;
        hold_y <= pend_y;
      end
      // A capture on the load edge lands in pending, never in the loaded frame
      if (capture_c) begin
        pend_x  <= x_coord;
        pend_y  <= y_coord;
        pending <= 1'b1;
      end else if (load_pend_c) begin
        pending <= 1'b0;
      end
      overrun    <= capture_c && pending && !load_pend_c;
      busy       <= (state_n == SHIFT);
      xy2_clk    <= (state_n == SHIFT) && !phase_n;
      xy2_sync   <= (state_n == SHIFT) && (bit_n != 5'd0);
      xy2_x      <= (state_n == SHIFT) && shx_n[FW-1];
      xy2_y      <= (state_n == SHIFT) && shy_n[FW-1];
      frame_done <= (state_n == SHIFT) && phase_n && (div_n == DIV_LAST) &&
                    (bit_n == 5'd0);
    end
  end

endmodule

// File: tb/tb_xy2_100_tx.sv
// Bench for xy2_100_tx: decodes the serial lines at each line-clock fall and
// compares whole frames against expectations queued when captures are driven.
module tb_xy2_100_tx;

  localparam int unsigned CD = 2;
  localparam logic [19:0] REP_FRAME = 20'h22468;

  logic        clk = 1'b0;
  logic        reset = 1'b1, reset1 = 1'b1;
  logic [15:0] x_coord = '0, y_coord = '0;
  logic        xy2_send = 1'b0;
  logic        clk0, sync0, x0, y0, busy0, done0, ovr0;
  logic        clk1, sync1, x1, y1, busy1, done1, ovr1;

  always #5 clk = ~clk;

  xy2_100_tx #(.CLK_DIV(CD), .REPEAT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .x_coord(x_coord), .y_coord(y_coord),
    .xy2_send(xy2_send), .xy2_clk(clk0), .xy2_sync(sync0), .xy2_x(x0),
    .xy2_y(y0), .busy(busy0), .frame_done(done0), .overrun(ovr0));

  xy2_100_tx #(.CLK_DIV(CD), .REPEAT(1'b1)) dut1 (
    .clk(clk), .reset(reset1), .x_coord(x_coord), .y_coord(y_coord),
    .xy2_send(xy2_send), .xy2_clk(clk1), .xy2_sync(sync1), .xy2_x(x1),
    .xy2_y(y1), .busy(busy1), .frame_done(done1), .overrun(ovr1));

  typedef struct {
    logic [19:0] fx;
    logic [19:0] fy;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [19:0] fx;
    logic [19:0] fy;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  int   ov_cnt   = 0;
  int   f1_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Receiver model for the REPEAT=0 instance
  logic [19:0] m0_x, m0_y;
  int          m0_n = 0;
  logic        m0_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      m0_n    = 0;
      m0_prev = 1'b0;
    end else begin
      if (m0_prev && !clk0) begin
        m0_x = {m0_x[18:0], x0};
        m0_y = {m0_y[18:0], y0};
        m0_n++;
        if (!sync0) begin
          if (exp_q.size() == 0) chk("frame_unexpected", 32'(m0_x), 32'hFFFFFFFF);
          else begin
            e = exp_q.pop_front();
            chk("frame_x", 32'(m0_x), 32'(e.fx));
            chk("frame_y", 32'(m0_y), 32'(e.fy));
            chk("frame_len", 32'(m0_n), 32'd20);
          end
          m0_n = 0;
        end
      end
      m0_prev = clk0;
      if (ovr0) ov_cnt++;
    end
  end

  // Receiver model for the REPEAT=1 instance
  logic [19:0] m1_x, m1_y;
  int          m1_n = 0;
  logic        m1_prev = 1'b0;
  always @(negedge clk) begin
    if (reset1) begin
      m1_n    = 0;
      m1_prev = 1'b0;
    end else begin
      if (m1_prev && !clk1) begin
        m1_x = {m1_x[18:0], x1};
        m1_y = {m1_y[18:0], y1};
        m1_n++;
        if (!sync1) begin
          chk("rep_frame_x", 32'(m1_x), 32'(REP_FRAME));
          chk("rep_frame_y", 32'(m1_y), 32'(REP_FRAME));
          chk("rep_frame_len", 32'(m1_n), 32'd20);
          f1_cnt++;
          m1_n = 0;
        end
      end
      m1_prev = clk1;
    end
  end

  task automatic pulse(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    x_coord  = x;
    y_coord  = y;
    xy2_send = 1'b1;
    @(negedge clk);
    xy2_send = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(busy0), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    logic [6:0] acc;
    int n, lowcnt, ov0;
    vecs[0] = '{16'h0000, 16'hFFFF, 20'h20001, 20'h3FFFF};
    vecs[1] = '{16'h8000, 16'h0001, 20'h30000, 20'h20002};
    vecs[2] = '{16'hA5A5, 16'h0F0E, 20'h34B4B, 20'h21E1C};
    vecs[3] = '{16'h1234, 16'h1111, 20'h22468, 20'h22223};

    // Reset state
    @(posedge clk); #1;
    chk("reset_outs0", 32'({clk0, sync0, x0, y0, busy0, done0, ovr0}), 32'd0);
    chk("reset_outs1", 32'({clk1, sync1, x1, y1, busy1, done1, ovr1}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Idle quiet
    acc = '0;
    repeat (200) begin
      @(posedge clk); #1;
      acc |= {clk0, sync0, x0, y0, busy0, done0, ovr0};
    end
    chk("idle_quiet", 32'(acc), 32'd0);

    // Single frames from the vector table, with latency and period checks
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{vecs[i].fx, vecs[i].fy});
      @(negedge clk);
      x_coord  = vecs[i].x;
      y_coord  = vecs[i].y;
      xy2_send = 1'b1;
      @(posedge clk); #1;
      chk("pre_load_idle", 32'(busy0), 32'd0);
      @(negedge clk);
      xy2_send = 1'b0;
      @(posedge clk); #1;
      chk("first_bit", 32'({clk0, sync0, busy0}), 32'b111);
      n = 1;
      while (!done0 && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      chk("frame_done_cycle", 32'(n), 32'(40 * CD));
      @(posedge clk); #1;
      chk("idle_after", 32'({clk0, sync0, busy0}), 32'd0);
    end

    // Two captures during one frame: overrun once, newest value sent next
    ov0 = ov_cnt;
    exp_q.push_back('{20'h21E1C, 20'h21E1C});
    exp_q.push_back('{20'h24445, 20'h24445});
    pulse(16'h0F0E, 16'h0F0E);
    repeat (10) @(posedge clk);
    pulse(16'h1111, 16'h1111);
    repeat (10) @(posedge clk);
    pulse(16'h2222, 16'h2222);
    #1;
    wait_idle("overrun_idle");
    chk("overrun_count", 32'(ov_cnt - ov0), 32'd1);

    // Reset in the middle of bit 10 aborts the frame
    pulse(16'hA5A5, 16'hA5A5);
    repeat (38) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midframe_reset", 32'({clk0, sync0, x0, y0, busy0, done0, ovr0}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    acc = '0;
    repeat (60) begin
      @(posedge clk); #1;
      acc |= {clk0, sync0, x0, y0, busy0, done0, ovr0};
    end
    chk("post_reset_quiet", 32'(acc), 32'd0);
    exp_q.push_back('{20'h34B4B, 20'h34B4B});
    pulse(16'hA5A5, 16'hA5A5);
    #1;
    wait_idle("post_reset_frame_idle");

    // REPEAT=1: gapless identical frames every 40*CLK_DIV cycles
    @(negedge clk);
    reset1 = 1'b0;
    exp_q.push_back('{REP_FRAME, REP_FRAME});
    pulse(16'h1234, 16'h1234);
    n = 0;
    while (!done1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rep_first_done", 32'(done1), 32'd1);
    lowcnt = 0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
        if (!busy1) lowcnt++;
      end while (!done1 && n < 300);
      chk("rep_period", 32'(n), 32'(40 * CD));
    end
    chk("rep_busy_gapless", 32'(lowcnt), 32'd0);
    chk("rep_frames_seen", 32'(f1_cnt >= 3), 32'd1);
    wait_idle("final_idle");
    repeat (4) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
